// File: rtl/axil_reg_selftest_if.sv
// AXI4-Lite master/slave bundle used by the register self-test engine.
interface axil_if #(
  parameter int AW = 32,
  parameter int DW = 32
) ();
  logic [AW-1:0]   awaddr;
  logic [2:0]      awprot;
  logic            awvalid;
  logic            awready;
  logic [DW-1:0]   wdata;
  logic [DW/8-1:0] wstrb;
  logic            wvalid;
  logic            wready;
  logic [1:0]      bresp;
  logic            bvalid;
  logic            bready;
  logic [AW-1:0]   araddr;
  logic [2:0]      arprot;
  logic            arvalid;
  logic            arready;
  logic [DW-1:0]   rdata;
  logic [1:0]      rresp;
  logic            rvalid;
  logic            rready;

  modport master (
    output awaddr, awprot, awvalid, input awready,
    output wdata, wstrb, wvalid, input wready,
    input bresp, bvalid, output bready,
    output araddr, arprot, arvalid, input arready,
    input rdata, rresp, rvalid, output rready
  );

  modport slave (
    input awaddr, awprot, awvalid, output awready,
    input wdata, wstrb, wvalid, output wready,
    output bresp, bvalid, input bready,
    input araddr, arprot, arvalid, output arready,
    output rdata, rresp, rvalid, input rready
  );
endinterface

// File: rtl/axil_reg_selftest.sv
// AXI4-Lite register self-test: writes a pattern to each register, reads it
// back, compares, and reports pass/fail with an error count and first-fail address.
module axil_reg_selftest #(
  parameter int          C_M_AXI_ADDR_WIDTH = 32,
  parameter int          C_M_AXI_DATA_WIDTH = 32,
  parameter int          C_NUM_REGS         = 4,
  parameter int unsigned C_BASE_ADDR        = 0,
  parameter int          C_TIMEOUT          = 1024
) (
  input  logic                          m00_axi_aclk,
  input  logic                          m00_axi_areset,
  input  logic                          start,
  input  logic [1:0]                    mode,
  input  logic [C_M_AXI_DATA_WIDTH-1:0] seed,
  input  logic                          stop_on_err,
  output logic                          busy,
  output logic                          done,
  output logic                          pass,
  output logic [15:0]                   err_count,
  output logic [C_M_AXI_ADDR_WIDTH-1:0] fail_addr,
  axil_if.master                        m00_axi
);

  localparam int AW  = C_M_AXI_ADDR_WIDTH;
  localparam int DW  = C_M_AXI_DATA_WIDTH;
  localparam int SHW = $clog2(DW);
  localparam logic [31:0] TO_LAST = 32'(C_TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_WRITE, S_WRESP, S_READ, S_RDATA, S_CHECK, S_FINISH
  } state_t;

  state_t          state, next_state;
  logic [1:0]      mode_r;
  logic            stop_r;
  logic [DW-1:0]   sum;
  logic [31:0]     lfsr;
  logic [31:0]     lfsr_next;
  logic [8:0]      idx;
  logic [AW-1:0]   addr;
  logic            aw_done, w_done;
  logic [DW-1:0]   rdata_r;
  logic [31:0]     tcnt;
  logic [DW-1:0]   pattern;
  logic            aw_hs, w_hs, ar_hs, aw_all, w_all;
  logic            timed_out, last, err_ev, adv;

  always_comb begin
    pattern = '0;
    unique case (mode_r)
      2'd0:    pattern = sum;
      2'd1:    pattern = DW'(1) << sum[SHW-1:0];
      2'd2:    pattern = DW'(lfsr);
      default: pattern = ~sum;
    endcase
  end

  // Galois form of x^32 + x^22 + x^2 + x + 1, shifting right.
  assign lfsr_next = {1'b0, lfsr[31:1]} ^ (lfsr[0] ? 32'h8020_0003 : '0);

  assign m00_axi.awaddr  = addr;
  assign m00_axi.araddr  = addr;
  assign m00_axi.awprot  = '0;
  assign m00_axi.arprot  = '0;
  assign m00_axi.wdata   = pattern;
  assign m00_axi.wstrb   = '1;
  assign m00_axi.awvalid = (state == S_WRITE) && !aw_done;
  assign m00_axi.wvalid  = (state == S_WRITE) && !w_done;
  assign m00_axi.bready  = (state == S_WRESP);
  assign m00_axi.arvalid = (state == S_READ);
  assign m00_axi.rready  = (state == S_RDATA);

  assign aw_hs     = m00_axi.awvalid && m00_axi.awready;
  assign w_hs      = m00_axi.wvalid && m00_axi.wready;
  assign ar_hs     = m00_axi.arvalid && m00_axi.arready;
  assign aw_all    = aw_done || aw_hs;
  assign w_all     = w_done || w_hs;
  assign timed_out = (tcnt == TO_LAST);
  assign last      = (idx == 9'(C_NUM_REGS - 1));

  assign busy = (state != S_IDLE);
  assign done = (state == S_FINISH);

  always_comb begin
    next_state = state;
    err_ev     = 1'b0;
    adv        = 1'b0;
    unique case (state)
      S_IDLE:   if (start) next_state = S_WRITE;
      S_WRITE: begin
        if (aw_all && w_all) next_state = S_WRESP;
        else if (timed_out) begin err_ev = 1'b1; adv = 1'b1; end
      end
      S_WRESP: begin
        if (m00_axi.bvalid) begin
          next_state = S_READ;
          err_ev     = (m00_axi.bresp != 2'b00);
        end else if (timed_out) begin err_ev = 1'b1; adv = 1'b1; end
      end
      S_READ: begin
        if (ar_hs) next_state = S_RDATA;
        else if (timed_out) begin err_ev = 1'b1; adv = 1'b1; end
      end
      S_RDATA: begin
        if (m00_axi.rvalid) begin
          next_state = S_CHECK;
          err_ev     = (m00_axi.rresp != 2'b00);
        end else if (timed_out) begin err_ev = 1'b1; adv = 1'b1; end
      end
      S_CHECK: begin
        err_ev = (rdata_r != pattern);
        adv    = 1'b1;
      end
      S_FINISH: next_state = S_IDLE;
      default:  next_state = S_IDLE;
    endcase
    // A timed-out transaction is abandoned and the run moves on like a CHECK.
    if (adv) next_state = last ? S_FINISH : S_WRITE;
    if (err_ev && stop_r) next_state = S_FINISH;
  end

  always_ff @(posedge m00_axi_aclk) begin
    if (m00_axi_areset) begin
      state     <= S_IDLE;
      mode_r    <= '0;
      stop_r    <= 1'b0;
      sum       <= '0;
      lfsr      <= 32'd1;
      idx       <= '0;
      addr      <= '0;
      aw_done   <= 1'b0;
      w_done    <= 1'b0;
      rdata_r   <= '0;
      tcnt      <= '0;
      err_count <= '0;
      fail_addr <= '0;
      pass      <= 1'b0;
    end else begin
      state   <= next_state;
      tcnt    <= (state == S_IDLE || next_state != state) ? '0 : tcnt + 32'd1;
      aw_done <= (state == S_WRITE && next_state == S_WRITE) ? aw_all : 1'b0;
      w_done  <= (state == S_WRITE && next_state == S_WRITE) ? w_all : 1'b0;
      if (state == S_RDATA && m00_axi.rvalid) rdata_r <= m00_axi.rdata;
      if (state == S_IDLE && start) begin
        mode_r    <= mode;
        stop_r    <= stop_on_err;
        sum       <= seed;
        lfsr      <= (seed[31:0] == 32'd0) ? 32'd1 : seed[31:0];
        idx       <= '0;
        addr      <= AW'(C_BASE_ADDR);
        err_count <= '0;
        fail_addr <= '0;
        pass      <= 1'b0;
      end
      if (adv && next_state == S_WRITE) begin
        idx  <= idx + 9'd1;
        sum  <= sum + DW'(1);
        lfsr <= lfsr_next;
        addr <= addr + AW'(DW / 8);
      end
      if (err_ev) begin
        if (err_count != 16'hFFFF) err_count <= err_count + 16'd1;
        if (err_count == 16'd0) fail_addr <= addr;
      end
      if (state == S_FINISH) pass <= (err_count == 16'd0);
    end
  end

endmodule

// File: tb/tb_axil_reg_selftest.sv
// Directed bench for axil_reg_selftest against a small echoing register slave.
module tb_axil_reg_selftest;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [1:0]  mode = '0;
  logic [31:0] seed = '0;
  logic        stop_on_err = 1'b0;
  logic        busy, done, pass;
  logic [15:0] err_count;
  logic [31:0] fail_addr;

  int total = 0;
  int bad = 0;

  axil_if #(.AW(32), .DW(32)) bus ();

  axil_reg_selftest #(
    .C_M_AXI_ADDR_WIDTH(32),
    .C_M_AXI_DATA_WIDTH(32),
    .C_NUM_REGS(4),
    .C_BASE_ADDR(0),
    .C_TIMEOUT(16)
  ) dut (
    .m00_axi_aclk(clk),
    .m00_axi_areset(rst),
    .start(start),
    .mode(mode),
    .seed(seed),
    .stop_on_err(stop_on_err),
    .busy(busy),
    .done(done),
    .pass(pass),
    .err_count(err_count),
    .fail_addr(fail_addr),
    .m00_axi(bus)
  );

  always #5 clk = ~clk;

  // Slave model knobs
  int   aw_delay = 0;
  int   w_delay = 0;
  int   fault_reg = -1;
  logic aw_block = 1'b0;

  logic [31:0] mem [16];
  logic [31:0] wlog_a [64];
  logic [31:0] wlog_d [64];
  logic [31:0] aw_l, w_l;
  logic        got_aw, got_w;
  int aw_wait = 0, w_wait = 0;
  int wr_count = 0, rd_count = 0, rd_c_count = 0, done_cnt = 0;

  assign bus.awready = bus.awvalid && !aw_block && (aw_wait >= aw_delay);
  assign bus.wready  = bus.wvalid && (w_wait >= w_delay);
  assign bus.arready = bus.arvalid;
  assign bus.bresp   = 2'b00;
  assign bus.rresp   = 2'b00;

  always @(posedge clk) begin
    if (rst) begin
      got_aw <= 1'b0; got_w <= 1'b0;
      bus.bvalid <= 1'b0; bus.rvalid <= 1'b0; bus.rdata <= '0;
      aw_wait <= 0; w_wait <= 0;
    end else begin
      if (bus.awvalid && bus.awready) begin got_aw <= 1'b1; aw_l <= bus.awaddr; aw_wait <= 0; end
      else if (bus.awvalid) aw_wait <= aw_wait + 1;
      if (bus.wvalid && bus.wready) begin got_w <= 1'b1; w_l <= bus.wdata; w_wait <= 0; end
      else if (bus.wvalid) w_wait <= w_wait + 1;
      if (got_aw && got_w && !bus.bvalid) begin
        bus.bvalid <= 1'b1;
        mem[aw_l[5:2]] <= w_l;
        wlog_a[wr_count % 64] <= aw_l;
        wlog_d[wr_count % 64] <= w_l;
        wr_count <= wr_count + 1;
        got_aw <= 1'b0; got_w <= 1'b0;
      end else if (bus.bvalid && bus.bready) bus.bvalid <= 1'b0;
      if (bus.arvalid && bus.arready) begin
        bus.rvalid <= 1'b1;
        bus.rdata  <= (int'(bus.araddr[5:2]) == fault_reg) ? 32'd0 : mem[bus.araddr[5:2]];
        rd_count   <= rd_count + 1;
        if (bus.araddr == 32'hC) rd_c_count <= rd_c_count + 1;
      end else if (bus.rvalid && bus.rready) bus.rvalid <= 1'b0;
    end
  end

  always @(posedge clk) if (done) done_cnt <= done_cnt + 1;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  int wr_base, rd_base, rdc_base, done_base, aw_hi, w_hi, cyc;

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic run(input logic [1:0] m, input logic [31:0] sd, input logic st,
                     input int restart_at);
    int n;
    mode = m; seed = sd; stop_on_err = st; start = 1'b1;
    wr_base = wr_count; rd_base = rd_count; rdc_base = rd_c_count; done_base = done_cnt;
    aw_hi = 0; w_hi = 0; cyc = -1; n = 0;
    while (n < 2000 && cyc < 0) begin
      @(posedge clk); #1;
      start = 1'b0;
      n++;
      if (n == restart_at) begin start = 1'b1; mode = 2'd0; seed = 32'h55; end
      if (bus.awvalid) aw_hi++;
      if (bus.wvalid) w_hi++;
      if (done) begin cyc = n; chk("busy_at_done", busy, 1); end
    end
    if (cyc < 0) chk("run_bound", 0, 1);
    @(posedge clk); #1;
    chk("done_width", done, 0);
    chk("busy_after", busy, 0);
    chk("done_count", done_cnt - done_base, 1);
  endtask

  task automatic check_wr(input logic [31:0] d0, d1, d2, d3);
    logic [31:0] e [4];
    e = '{d0, d1, d2, d3};
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("waddr%0d", i), wlog_a[(wr_base + i) % 64], 32'(4 * i));
      chk($sformatf("wdata%0d", i), wlog_d[(wr_base + i) % 64], e[i]);
    end
  endtask

  initial begin
    int n;
    int dc;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_pass", pass, 0);
    chk("rst_err", err_count, 0);
    chk("rst_faddr", fail_addr, 0);
    chk("rst_valids", {bus.awvalid, bus.wvalid, bus.arvalid, bus.bready, bus.rready}, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Clean mode 0 run with zero-wait slave
    run(2'd0, 32'h0101FFFF, 1'b0, 0);
    chk("latency", cyc, 25);
    chk("m0_pass", pass, 1);
    chk("m0_err", err_count, 0);
    chk("m0_writes", wr_count - wr_base, 4);
    chk("m0_reads", rd_count - rd_base, 4);
    check_wr(32'h0101FFFF, 32'h01020000, 32'h01020001, 32'h01020002);

    run(2'd1, 32'd30, 1'b0, 0);
    chk("m1_pass", pass, 1);
    check_wr(32'h40000000, 32'h80000000, 32'h00000001, 32'h00000002);

    run(2'd2, 32'd0, 1'b0, 0);
    chk("m2_pass", pass, 1);
    check_wr(32'h00000001, 32'h80200003, 32'hC0300002, 32'h60180001);

    // Mode 3 with a second start pulse mid-run, which must be ignored
    run(2'd3, 32'd0, 1'b0, 5);
    chk("m3_pass", pass, 1);
    chk("m3_writes", wr_count - wr_base, 4);
    check_wr(32'hFFFFFFFF, 32'hFFFFFFFE, 32'hFFFFFFFD, 32'hFFFFFFFC);

    // Read fault at register 2, continue
    fault_reg = 2;
    run(2'd0, 32'h0101FFFF, 1'b0, 0);
    chk("f0_err", err_count, 1);
    chk("f0_faddr", fail_addr, 32'h8);
    chk("f0_pass", pass, 0);
    chk("f0_reads", rd_count - rd_base, 4);

    // Same fault, abort on first error
    run(2'd0, 32'h0101FFFF, 1'b1, 0);
    chk("f1_err", err_count, 1);
    chk("f1_faddr", fail_addr, 32'h8);
    chk("f1_pass", pass, 0);
    chk("f1_reads", rd_count - rd_base, 3);
    chk("f1_no_c", rd_c_count - rdc_base, 0);
    fault_reg = -1;

    // awready withheld: 16-cycle timeout, abort
    aw_block = 1'b1;
    run(2'd0, 32'd0, 1'b1, 0);
    chk("to_aw_cycles", aw_hi, 16);
    chk("to_w_cycles", w_hi, 1);
    chk("to_latency", cyc, 17);
    chk("to_err", err_count, 1);
    chk("to_faddr", fail_addr, 0);
    chk("to_writes", wr_count - wr_base, 0);
    chk("to_awvalid", bus.awvalid, 0);
    aw_block = 1'b0;
    do_reset();

    // wready three cycles after awready
    w_delay = 3;
    run(2'd0, 32'h0101FFFF, 1'b0, 0);
    chk("wlate_aw", aw_hi, 4);
    chk("wlate_w", w_hi, 16);
    chk("wlate_writes", wr_count - wr_base, 4);
    chk("wlate_pass", pass, 1);
    w_delay = 0;

    // awready three cycles after wready
    aw_delay = 3;
    run(2'd0, 32'h0101FFFF, 1'b0, 0);
    chk("awlate_aw", aw_hi, 16);
    chk("awlate_w", w_hi, 4);
    chk("awlate_writes", wr_count - wr_base, 4);
    chk("awlate_pass", pass, 1);
    aw_delay = 0;

    // Reset while in RDATA
    mode = 2'd0; seed = 32'd5; stop_on_err = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    n = 0;
    while (!bus.rready && n < 100) begin @(posedge clk); #1; n++; end
    chk("reach_rdata", bus.rready, 1);
    dc = done_cnt;
    rst = 1'b1;
    @(posedge clk); #1;
    chk("mr_busy", busy, 0);
    chk("mr_valids", {bus.awvalid, bus.wvalid, bus.arvalid, bus.rready}, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (40) @(posedge clk);
    #1;
    chk("mr_no_done", done_cnt - dc, 0);
    chk("mr_idle", busy, 0);

    run(2'd0, 32'h0101FFFF, 1'b0, 0);
    chk("post_pass", pass, 1);
    chk("post_err", err_count, 0);
    chk("post_latency", cyc, 25);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/axil_reg_selftest.md
AXIL_REG_SELFTEST -- requirements
Module: axil_reg_selftest

Interface
REQ-001 SHALL have parameter C_M_AXI_ADDR_WIDTH, default 32, AXI address width.
REQ-002 SHALL have parameter C_M_AXI_DATA_WIDTH, default 32, AXI data width; legal values 32 or 64.
REQ-003 SHALL have parameter C_NUM_REGS, default 4, number of consecutive registers tested; legal range 1..256.
REQ-004 SHALL have parameter C_BASE_ADDR, default 0, byte address of register 0.
REQ-005 SHALL have parameter C_TIMEOUT, default 1024, maximum cycles allowed for any single handshake.
REQ-006 SHALL use one clock and a synchronous active-high reset: m00_axi_aclk (in, 1, clock), then m00_axi_areset (in, 1, reset, sampled on the rising edge of m00_axi_aclk).
REQ-007 SHALL have port start, in, 1: pulse that launches a test run.
REQ-008 SHALL have port mode, in, 2: pattern select, sampled at start.
REQ-009 SHALL have port seed, in, DW: pattern seed, sampled at start.
REQ-010 SHALL have port stop_on_err, in, 1: abort the run on the first error, sampled at start.
REQ-011 SHALL have port busy, out, 1: run in progress.
REQ-012 SHALL have port done, out, 1: one-cycle pulse at the end of a run.
REQ-013 SHALL have port pass, out, 1: result of the last run, held until the next start.
REQ-014 SHALL have port err_count, out, 16: saturating error count.
REQ-015 SHALL have port fail_addr, out, AW: address of the first failing register.
REQ-016 SHALL have the AW channel: m00_axi_awaddr (out, AW), m00_axi_awprot (out, 3), m00_axi_awvalid (out, 1), m00_axi_awready (in, 1).
REQ-017 SHALL have the W channel: m00_axi_wdata (out, DW), m00_axi_wstrb (out, DW/8), m00_axi_wvalid (out, 1), m00_axi_wready (in, 1).
REQ-018 SHALL have the B channel: m00_axi_bresp (in, 2), m00_axi_bvalid (in, 1), m00_axi_bready (out, 1).
REQ-019 SHALL have the AR channel: m00_axi_araddr (out, AW), m00_axi_arprot (out, 3), m00_axi_arvalid (out, 1), m00_axi_arready (in, 1).
REQ-020 SHALL have the R channel: m00_axi_rdata (in, DW), m00_axi_rresp (in, 2), m00_axi_rvalid (in, 1), m00_axi_rready (out, 1).

Function
REQ-021 SHALL implement the FSM IDLE -> WRITE -> WRESP -> READ -> RDATA -> CHECK, then back to WRITE for the next index or on to FINISH -> IDLE.
REQ-022 SHALL, in IDLE, act on start only; start while busy SHALL be ignored.
REQ-023 SHALL generate the pattern for index i according to mode: 0 = seed+i (mod 2^DW); 1 = walking one, 1<<((seed+i) mod DW); 2 = 32-bit Galois LFSR (taps 32,22,2,1) seeded by seed (zero seed replaced by 1), advanced once per index and zero-extended to DW; 3 = ~(seed+i).
REQ-024 SHALL use address C_BASE_ADDR + i*(DW/8); awprot and arprot SHALL be 0; wstrb SHALL be all ones.
REQ-025 SHALL, in WRITE, assert awvalid and wvalid in the same cycle and drop each independently after its own handshake; the FSM SHALL advance to WRESP once both handshakes have occurred, in either order or together.
REQ-026 SHALL hold bready and rready high only in WRESP and RDATA respectively.
REQ-027 SHALL hold each valid stable until its ready is seen; address and data SHALL not change while valid is high.
REQ-028 SHALL count an error when bresp != 2'b00, when rresp != 2'b00, when rdata differs from the written pattern, or when a handshake times out.
REQ-029 SHALL detect timeout when a state's handshake is still pending C_TIMEOUT cycles after state entry; the transaction SHALL then be abandoned (valids dropped), one error counted, and the run advanced or aborted per REQ-031.
REQ-030 SHALL saturate err_count at 16'hFFFF; fail_addr SHALL be captured on the first error of a run only.
REQ-031 SHALL, when stop_on_err=1, go from the state of the first error directly to FINISH.
REQ-032 SHALL, in FINISH, pulse done for one cycle and set pass = (err_count == 0); busy SHALL be high from the cycle after start until the cycle done is high, inclusive.
REQ-033 SHALL, on start, clear err_count and fail_addr and set the index to 0.
REQ-034 SHALL give a minimum run latency of 6 cycles per register plus 1 cycle, with zero-wait slave ready.

Reset
REQ-035 SHALL, while m00_axi_areset=1, force the FSM to IDLE; all valid/ready outputs, busy, done, pass and err_count SHALL be 0; fail_addr SHALL be 0.
REQ-036 SHALL, on reset mid-transaction, drop valids in the next cycle and issue no further transfers; no done pulse SHALL be produced.

Verification
REQ-037 SHALL cover: mode 0, seed 32'h0101FFFF, C_NUM_REGS=4, echoing register slave -> 4 writes and 4 reads at 0x0,0x4,0x8,0xC; done pulses; pass=1; err_count=0.
REQ-038 SHALL cover: slave returns 0 at reg 2, stop_on_err=0 -> err_count=1, fail_addr=0x8, pass=0, all 4 registers read.
REQ-039 SHALL cover: same fault with stop_on_err=1 -> no access to 0xC, err_count=1, done pulse.
REQ-040 SHALL cover: slave withholds awready with C_TIMEOUT=16 -> timeout after 16 cycles, awvalid drops, err_count increments.
REQ-041 SHALL cover: wready asserted 3 cycles after awready, and the reverse order -> each valid drops independently and one write completes.
REQ-042 SHALL cover: reset asserted during RDATA -> busy=0, no done pulse; a subsequent start runs cleanly.
